// File: rtl/pwq_pkg.sv
// Shared types and constants for the pixel write queue.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package pwq_pkg;

    localparam int ADDR_W            = 19;
    localparam int DATA_W            = 3;
    localparam int FB_PIXELS_DEFAULT = 307200;

    // One queued framebuffer write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pwq_entry_t;

    // Event counter that sticks at all-ones instead of wrapping
    typedef logic [15:0] pwq_cnt_t;

    function automatic pwq_cnt_t pwq_sat_inc(input pwq_cnt_t cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/pwq_storage.sv
// Entry array for the pixel write queue: one write port, async head read, in-place tail data update.
// Latency: writes visible on the read port the cycle after the write edge; reads are combinational.
// Backpressure: none here; the owner decides when the write ports may fire.
module pwq_storage
    import pwq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  pwq_entry_t        wr_entry,
    input  logic [PTR_W-1:0]  rd_ptr,
    output pwq_entry_t        rd_entry,
    input  logic              tail_en,
    input  logic [PTR_W-1:0]  tail_ptr,
    input  logic [DATA_W-1:0] tail_data
);

    pwq_entry_t mem [DEPTH];

    // Append a new entry, or overwrite only the colour of the youngest entry
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end else if (tail_en) begin
            mem[tail_ptr].data <= tail_data;
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/pixel_write_queue.sv
// Buffers pixel writes and drains them into the framebuffer port on granted cycles; PWQ_COALESCE_EN merges same-address writes to the tail.
// Latency: accept at edge E, earliest fb_wenable after edge E+1 (fb_grant high); then 1 write/cycle while granted.
// Backpressure: in_ready = (level != DEPTH); full in-range writes are dropped and counted, out-of-frame writes are counted and discarded.
module pixel_write_queue
    import pwq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FB_PIXELS = FB_PIXELS_DEFAULT
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [ADDR_W-1:0]          in_waddr,
    input  logic [DATA_W-1:0]          in_wdata,
    input  logic                       in_wenable,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       fb_grant,
    output logic [ADDR_W-1:0]          fb_waddr,
    output logic [DATA_W-1:0]          fb_wdata,
    output logic                       fb_wenable,
    output logic [$clog2(DEPTH):0]     level,
    output pwq_cnt_t                   drop_count,
    output pwq_cnt_t                   oob_count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [31:0]       FB_LIM   = 32'(FB_PIXELS);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [LVL_W-1:0] level_q;
    pwq_entry_t       head_entry;
    pwq_entry_t       new_entry;
    logic             in_range;
    logic             not_empty;
    logic             pop;
    logic             push;
    logic             coalesce;
    logic             drop;
    logic             oob;

    // Reset drops asynchronously but leaves on a clock edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign in_range  = ({{(32-ADDR_W){1'b0}}, in_waddr} < FB_LIM);
    assign not_empty = (level_q != '0);
    assign in_ready  = (level_q != LVL_FULL);
    assign pop       = fb_grant && not_empty && !flush;
    assign tail_ptr  = wr_ptr - 1'b1;
    assign new_entry = '{addr: in_waddr, data: in_wdata};

`ifdef PWQ_COALESCE_EN
    logic [ADDR_W-1:0] tail_addr_q;

    // Tail merge is legal only while the tail is queued and not leaving this cycle
    always_comb begin
        coalesce = in_wenable && in_range && !flush && not_empty
                   && (in_waddr == tail_addr_q)
                   && !(pop && (level_q == LVL_ONE));
    end

    // Track the youngest entry's address so the storage needs no second read port
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tail_addr_q <= '0;
        end else if (push) begin
            tail_addr_q <= in_waddr;
        end
    end
`else
    assign coalesce = 1'b0;
`endif

    // Classify the incoming write: new entry, merge, lost to full, or out of frame
    always_comb begin
        push = in_wenable && in_range && !flush && in_ready && !coalesce;
        drop = in_wenable && in_range && !flush && !in_ready && !coalesce;
        oob  = in_wenable && !in_range;
    end

    pwq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clock     (clock),
        .wr_en     (push),
        .wr_ptr    (wr_ptr),
        .wr_entry  (new_entry),
        .rd_ptr    (rd_ptr),
        .rd_entry  (head_entry),
        .tail_en   (coalesce),
        .tail_ptr  (tail_ptr),
        .tail_data (in_wdata)
    );

    // Pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Framebuffer port: strobe for one cycle per popped entry, hold address/data otherwise
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fb_waddr   <= '0;
            fb_wdata   <= '0;
            fb_wenable <= 1'b0;
        end else if (pop) begin
            fb_waddr   <= head_entry.addr;
            fb_wdata   <= head_entry.data;
            fb_wenable <= 1'b1;
        end else begin
            fb_wenable <= 1'b0;
        end
    end

    // Loss counters survive flush and stick at their maximum
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            oob_count  <= '0;
        end else begin
            if (drop) begin
                drop_count <= pwq_sat_inc(drop_count);
            end
            if (oob) begin
                oob_count <= pwq_sat_inc(oob_count);
            end
        end
    end

    assign level = level_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Randomized and directed bench for pixel_write_queue against a queue-based reference model.
// Latency: checks each edge's outputs 1 ns after the rising edge.
// Backpressure: model predicts in_ready, drops and out-of-frame rejects.
module tb_pixel_write_queue;
    import pwq_pkg::*;

    localparam int DEPTH = 16;
    localparam int FBP   = 307200;

    logic              clock;
    logic              resetn;
    logic [ADDR_W-1:0] in_waddr;
    logic [DATA_W-1:0] in_wdata;
    logic              in_wenable;
    logic              in_ready;
    logic              flush;
    logic              fb_grant;
    logic [ADDR_W-1:0] fb_waddr;
    logic [DATA_W-1:0] fb_wdata;
    logic              fb_wenable;
    logic [4:0]        level;
    pwq_cnt_t          drop_count;
    pwq_cnt_t          oob_count;

    pixel_write_queue #(.DEPTH(DEPTH), .FB_PIXELS(FBP)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .in_wenable (in_wenable),
        .in_ready   (in_ready),
        .flush      (flush),
        .fb_grant   (fb_grant),
        .fb_waddr   (fb_waddr),
        .fb_wdata   (fb_wdata),
        .fb_wenable (fb_wenable),
        .level      (level),
        .drop_count (drop_count),
        .oob_count  (oob_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    int                m_drop;
    int                m_oob;
    logic [ADDR_W-1:0] m_fa;
    logic [DATA_W-1:0] m_fd;
    int                n_checks;
    int                n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_oob  = 0;
        m_fa   = '0;
        m_fd   = '0;
    endtask

    // One clock cycle: drive, predict, then compare everything the model knows
    task automatic step(input logic wen, input int addr, input int data,
                        input logic grant, input logic fl);
        logic pop_now;
        logic do_push;
        logic co;
        logic exp_wen;
        ent_t head;
        ent_t t;
        @(negedge clock);
        in_wenable = wen;
        in_waddr   = ADDR_W'(addr);
        in_wdata   = DATA_W'(data);
        fb_grant   = grant;
        flush      = fl;
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, (mq.size() != DEPTH)});
        exp_wen = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            pop_now = grant && (mq.size() > 0);
            do_push = 1'b0;
            co      = 1'b0;
            if (wen) begin
                if (addr >= FBP) begin
                    m_oob = sat16(m_oob);
                end else begin
`ifdef PWQ_COALESCE_EN
                    if (mq.size() > 0 && mq[mq.size()-1].a == ADDR_W'(addr)
                        && !(pop_now && mq.size() == 1)) begin
                        t = mq[mq.size()-1];
                        t.d = DATA_W'(data);
                        mq[mq.size()-1] = t;
                        co = 1'b1;
                    end
`endif
                    if (!co) begin
                        if (mq.size() == DEPTH) m_drop = sat16(m_drop);
                        else do_push = 1'b1;
                    end
                end
            end
            if (pop_now) begin
                head    = mq.pop_front();
                exp_wen = 1'b1;
                m_fa    = head.a;
                m_fd    = head.d;
            end
            if (do_push) begin
                t.a = ADDR_W'(addr);
                t.d = DATA_W'(data);
                mq.push_back(t);
            end
        end
        @(posedge clock);
        #1;
        chk("fb_wenable", {31'b0, fb_wenable}, {31'b0, exp_wen});
        chk("fb_waddr", 32'(fb_waddr), 32'(m_fa));
        chk("fb_wdata", 32'(fb_wdata), 32'(m_fd));
        chk("level", 32'(level), mq.size());
        chk("drop_count", 32'(drop_count), m_drop);
        chk("oob_count", 32'(oob_count), m_oob);
    endtask

    task automatic idle(input int n, input logic grant);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, grant, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        idle(3, 1'b0);
    endtask

    int last_addr;
    int a;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        in_waddr   = '0;
        in_wdata   = '0;
        in_wenable = 1'b0;
        flush      = 1'b0;
        fb_grant   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_fb_wenable", {31'b0, fb_wenable}, 0);
        chk("rst_fb_waddr", 32'(fb_waddr), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_oob", 32'(oob_count), 0);
        @(negedge clock);
        resetn = 1'b1;
        idle(3, 1'b0);

        // Latency: accept at E, strobe visible after E+1
        step(1'b1, 100, 5, 1'b1, 1'b0);
        chk("lat_no_early", {31'b0, fb_wenable}, 0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        chk("lat_wen", {31'b0, fb_wenable}, 1);
        chk("lat_addr", 32'(fb_waddr), 100);
        chk("lat_data", 32'(fb_wdata), 5);

        // Reset in the middle of a drain
        step(1'b1, 7, 1, 1'b1, 1'b0);
        step(1'b1, 8, 2, 1'b1, 1'b0);
        step(1'b1, 9, 3, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_wen", {31'b0, fb_wenable}, 0);
        chk("mid_rst_addr", 32'(fb_waddr), 0);
        chk("mid_rst_data", 32'(fb_wdata), 0);
        chk("mid_rst_level", 32'(level), 0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        idle(3, 1'b1);
        chk("post_rst_level", 32'(level), 0);

        // Fill past full with no grant, then drain in order
        for (int i = 0; i < 18; i++) step(1'b1, 1000 + i, i % 8, 1'b0, 1'b0);
        chk("full_level", 32'(level), 16);
        chk("full_ready", {31'b0, in_ready}, 0);
        chk("full_drop", 32'(drop_count), 2);
        idle(17, 1'b1);

        // Out-of-frame addresses are rejected, the last pixel is accepted
        step(1'b1, 307200, 1, 1'b0, 1'b0);
        step(1'b1, 524287, 2, 1'b0, 1'b0);
        chk("oob_count2", 32'(oob_count), 2);
        chk("oob_level0", 32'(level), 0);
        step(1'b1, 307199, 4, 1'b0, 1'b0);
        chk("oob_edge_acc", 32'(level), 1);
        idle(2, 1'b1);

        // Push and pop together at level 1
        step(1'b1, 500, 1, 1'b0, 1'b0);
        step(1'b1, 501, 2, 1'b1, 1'b0);
        chk("pp_level", 32'(level), 1);
        chk("pp_old_head", 32'(fb_waddr), 500);
        for (int i = 0; i < 4; i++) step(1'b1, 600 + i, i, 1'b0, 1'b0);
        chk("pre_flush_level", 32'(level), 5);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        chk("flush_level", 32'(level), 0);
        idle(3, 1'b1);

        // Same-address back-to-back writes
        step(1'b1, 42, 1, 1'b0, 1'b0);
        step(1'b1, 42, 6, 1'b0, 1'b0);
`ifdef PWQ_COALESCE_EN
        chk("coal_level", 32'(level), 1);
`else
        chk("coal_level", 32'(level), 2);
`endif
        idle(4, 1'b1);

        // Randomized traffic
        last_addr = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(1'b0, 0, 0, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                case ($urandom_range(0, 7))
                    0:       a = 307200 + $urandom_range(0, 524287 - 307200);
                    1, 2:    a = last_addr;
                    default: a = $urandom_range(0, 1023);
                endcase
                if (a < FBP) last_addr = a;
                step(1'($urandom_range(0, 3) != 0), a, $urandom_range(0, 7),
                     1'($urandom_range(0, 2) == 0), 1'b0);
            end
        end
        idle(DEPTH + 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
# pixel_write_queue

Buffers single-pixel framebuffer writes (19-bit address, 3-bit colour) produced by the character/trajectory writer stage and drains them into the framebuffer write port only on cycles the port is granted, such as VGA blanking. It sits directly downstream of the index writer's `mem_waddr`/`mem_wdata`/`mem_wenable` outputs and directly upstream of the framebuffer RAM. It absorbs bursts, applies backpressure, rejects out-of-frame addresses and counts lost writes.

## Interface
- `DEPTH`, 16 — queue entries; power of two, minimum 2.
- `FB_PIXELS`, 307200 — valid address range is 0..FB_PIXELS-1 (640x480).
- `clock`  in  1  — single clock; all state changes on its rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `in_waddr`  in  19  — pixel address from the writer.
- `in_wdata`  in  3  — pixel colour.
- `in_wenable`  in  1  — write request this cycle.
- `in_ready`  out  1  — queue can accept; combinational, equals `level != DEPTH`.
- `flush`  in  1  — synchronous; discards all pending entries.
- `fb_grant`  in  1  — framebuffer port available this cycle.
- `fb_waddr`  out  19  — registered write address to framebuffer.
- `fb_wdata`  out  3  — registered write data.
- `fb_wenable`  out  1  — registered write strobe, one cycle per entry.
- `level`  out  $clog2(DEPTH)+1  — current occupancy, registered.
- `drop_count`  out  16  — writes lost to a full queue; saturates at 16'hFFFF.
- `oob_count`  out  16  — writes rejected for `in_waddr >= FB_PIXELS`; saturates at 16'hFFFF.

## Operation
- Reset drives `fb_waddr`=0, `fb_wdata`=0, `fb_wenable`=0, `level`=0, `drop_count`=0, `oob_count`=0, and sets the read and write pointers to 0. The reset asserts asynchronously and is released synchronously.
- **Accept:** the block accepts a write when `in_wenable` && `in_ready` && `in_waddr < FB_PIXELS`. The entry is written at the tail, and the write pointer wraps modulo DEPTH.
- **Out of range:** `in_wenable` && `in_waddr >= FB_PIXELS` increments `oob_count` and stores nothing. This check takes priority over the full check.
- **Full:** `in_wenable` with an in-range address while `level == DEPTH` increments `drop_count`. The write is discarded. There is no pass-through, even if a pop happens in the same cycle.
- **Drain:** on each edge where `fb_grant` && `level != 0`, the head entry is registered onto `fb_*` with `fb_wenable`=1 and the read pointer advances. On any other edge, `fb_wenable`=0 and `fb_waddr`/`fb_wdata` hold their last values.
- **Push and pop together:** `level` is unchanged. When `level == 1`, the popped entry is the old head and the new entry becomes the head.
- **Flush:** the pointers and `level` reset to 0 and `fb_wenable`=0 on the next edge. A push or pop in the same cycle as `flush` is ignored. The counters are not cleared.
- **Counter arithmetic:** `level` is computed as a DEPTH+1 valued counter and never wraps. Both 16-bit counters saturate.

## Timing
- The accept edge is E. The earliest `fb_wenable` high is in the cycle after edge E+1, provided `fb_grant` is high at E+1. Minimum latency is 1 cycle; queue-to-port latency is unbounded and depends on `fb_grant`.
- Sustained throughput is 1 write/cycle while `fb_grant` stays high.
- `in_ready` falls in the same cycle `level` reaches DEPTH. It rises in the cycle after the first pop from a full queue.
- Writes leave in arrival order. No reordering occurs except the coalescing overwrite described under Configuration.

## Configuration
- `PWQ_COALESCE_EN` defined:
  - An accepted write whose address equals the address of the tail entry overwrites that entry's data in place. This applies only when the tail entry is still queued and is not being popped in the same cycle.
  - A coalesced write does not change `level` and is accepted even when `level == DEPTH`. It does not count as a drop.
  - If the tail entry is popped in the same cycle, the write is pushed as a new entry.
- `PWQ_COALESCE_EN` undefined: every accepted write occupies its own entry, and no address comparison logic is present.

## Structure
- Package `pwq_pkg` holds:
  - `ADDR_W`=19 and `DATA_W`=3;
  - `FB_PIXELS_DEFAULT`=307200;
  - typedef `pwq_entry_t` as a packed struct of address and data;
  - typedef `pwq_cnt_t` as the 16-bit saturating counter type.
- Sub-module `pwq_storage` holds DEPTH x `pwq_entry_t`, with a synchronous write port, an asynchronous read port at the read pointer, and an in-place tail write port for coalescing. Pointer, level, counter and output logic stay in `pixel_write_queue`.

## Test plan
- **Reset mid-drain:** push 3 entries with `fb_grant`=1, then pulse `resetn` low mid-stream. All outputs must go to 0 immediately, and `level`=0 after release.
- **Latency:** with `fb_grant`=1, push addr 100 / data 3'b101 at edge E. Expect `fb_wenable`=1, `fb_waddr`=100, `fb_wdata`=5 after edge E+1.
- **Full:** hold `fb_grant`=0 and push 18 distinct addresses with DEPTH=16. Expect `level`=16, `in_ready`=0 and `drop_count`=2. Then raise `fb_grant`: 16 writes drain in order, followed by `fb_wenable`=0.
- **Out of range:** push addr 307200 and addr 524287. Expect `oob_count`=2, `level`=0 and no `fb_wenable`. Push addr 307199: it is accepted.
- **Push and pop together:** at `level`=1 with `fb_grant`=1, push a new entry. `level` stays 1 and the old head is emitted first. Assert `flush` with `level`=5: expect `level`=0 next cycle and no further writes.
- **Coalescing (with `PWQ_COALESCE_EN`):** with `fb_grant`=0, push addr 42 data 1, then addr 42 data 6. Expect `level`=1 and a single drained write of 42/6. Without the macro: `level`=2, and 42/1 is drained before 42/6.
